// File: rtl/systolic_array_pkg.sv
// systolic_array_pkg: shared word type, FSM states and FP32 multiply
package systolic_array_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_W, ISSUE, COMPUTE} st_t;
  localparam word_t QNAN = 32'h7FC0_0000;
  function automatic word_t fp_mul(input word_t a, input word_t b);
    logic s, an, bn, ai, bi, az, bz, g, stk, rnd;
    logic [47:0] p;
    logic [22:0] f;
    logic [23:0] r;
    logic [9:0] t;
    s = a[31] ^ b[31];
    an = &a[30:23] && |a[22:0];
    bn = &b[30:23] && |b[22:0];
    ai = &a[30:23] && ~|a[22:0];
    bi = &b[30:23] && ~|b[22:0];
    az = ~|a[30:23];
    bz = ~|b[30:23];
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    {f, g, stk} = p[47] ? {p[46:24], p[23], |p[22:0]} : {p[45:23], p[22], |p[21:0]};
    rnd = g & (stk | f[0]);
    r = {1'b0, f} + {23'd0, rnd};
    t = {2'b0, a[30:23]} + {2'b0, b[30:23]} + {9'd0, p[47]} + {9'd0, r[23]};
    return (an | bn | (ai & bz) | (bi & az)) ? QNAN :
           (ai | bi | (t >= 10'd382)) ? {s, 8'hff, 23'd0} :
           (az | bz | (t <= 10'd127)) ? {s, 31'd0} :
           {s, 8'(t - 10'd127), r[22:0]};
  endfunction
endpackage

// File: rtl/systolic_array.sv
// systolic_array: N-lane FP32 multiply array with N-cycle compute stall
module systolic_array
  import systolic_array_pkg::*;
#(
  parameter int N = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  valid_i,
  input  word_t x_i [N-1:0],
  input  word_t w_i [N-1:0],
  output logic  stall_o,
  output logic  done_o,
  output word_t y_o [N-1:0]
);
  localparam int CW = $clog2(N + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  word_t y_q [N-1:0];
  word_t y_d [N-1:0];
  assign stall_o = cnt_q != '0;
  assign done_o = cnt_q == CW'(1);
  assign y_o = y_q;
  always_comb begin
    cnt_d = valid_i ? CW'(N) : stall_o ? cnt_q - CW'(1) : cnt_q;
    for (int i = 0; i < N; i++) y_d[i] = done_o ? fp_mul(x_i[i], w_i[i]) : y_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      y_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      y_q <= y_d;
    end
  end
endmodule

// File: rtl/top_pd.sv
// top_pd: two SPADs feeding an FP32 multiply array through a load/issue/compute FSM
module top_pd
  import systolic_array_pkg::*;
#(
  parameter int N = 4,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_x,
  input  logic [AW-1:0] base_addr_w,
  output logic          busy_o,
  output logic          sa_stall_o,
  output word_t         y_out [N-1:0],
  input  logic          spad_x_csb0,
  input  logic          spad_w_csb0,
  input  logic [AW-1:0] spad_x_addr0,
  input  logic [AW-1:0] spad_w_addr0,
  input  word_t         spad_x_din0,
  input  word_t         spad_w_din0
);
  localparam int IW = $clog2(N + 1);
  st_t st_q, st_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] bx_q, bx_d, bw_q, bw_d;
  word_t x_reg_q [N-1:0];
  word_t x_reg_d [N-1:0];
  word_t w_reg_q [N-1:0];
  word_t w_reg_d [N-1:0];
  word_t mem_x [2**AW];
  word_t mem_w [2**AW];
  logic csb1_x, csb1_w, last, sa_valid, sa_done;
  logic [AW-1:0] addr1_x, addr1_w;
  word_t dout1_x, dout1_w;
  assign last = idx_q == IW'(N);
  always_ff @(posedge clk) begin
    if (n_rst) begin
      st_q <= IDLE;
      idx_q <= '0;
      bx_q <= '0;
      bw_q <= '0;
      x_reg_q <= '{default: '0};
      w_reg_q <= '{default: '0};
    end else begin
      st_q <= st_d;
      idx_q <= idx_d;
      bx_q <= bx_d;
      bw_q <= bw_d;
      x_reg_q <= x_reg_d;
      w_reg_q <= w_reg_d;
    end
  end
  always_comb begin
    st_d = (st_q == IDLE && start_i) ? LOAD_X :
           (st_q == LOAD_X && last) ? LOAD_W :
           (st_q == LOAD_W && last) ? ISSUE :
           (st_q == ISSUE) ? COMPUTE :
           (st_q == COMPUTE && sa_done) ? IDLE : st_q;
  end
  always_comb begin
    busy_o = st_q != IDLE;
    csb1_x = !(st_q == LOAD_X && !last);
    csb1_w = !(st_q == LOAD_W && !last);
    addr1_x = bx_q + AW'(idx_q);
    addr1_w = bw_q + AW'(idx_q);
    sa_valid = st_q == ISSUE;
  end
  always_comb begin
    idx_d = ((st_q == LOAD_X || st_q == LOAD_W) && !last) ? idx_q + IW'(1) : '0;
    bx_d = (st_q == IDLE && start_i) ? base_addr_x : bx_q;
    bw_d = (st_q == IDLE && start_i) ? base_addr_w : bw_q;
    x_reg_d = x_reg_q;
    w_reg_d = w_reg_q;
    for (int i = 0; i < N; i++) begin
      if (st_q == LOAD_X && idx_q == IW'(i + 1)) x_reg_d[i] = dout1_x;
      if (st_q == LOAD_W && idx_q == IW'(i + 1)) w_reg_d[i] = dout1_w;
    end
  end
  always_ff @(posedge clk) begin
    if (!spad_x_csb0) mem_x[spad_x_addr0] <= spad_x_din0;
    if (!spad_w_csb0) mem_w[spad_w_addr0] <= spad_w_din0;
    if (!csb1_x) dout1_x <= mem_x[addr1_x];
    if (!csb1_w) dout1_w <= mem_w[addr1_w];
  end
  systolic_array #(.N(N)) U_SA (
    .clk(clk),
    .rst(n_rst),
    .valid_i(sa_valid),
    .x_i(x_reg_q),
    .w_i(w_reg_q),
    .stall_o(sa_stall_o),
    .done_o(sa_done),
    .y_o(y_out)
  );
endmodule

// File: tb/tb_top_pd.sv
// tb_top_pd: directed self-checking bench for top_pd
module tb_top_pd;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic start_i = 1'b0;
  logic [5:0] base_addr_x = '0, base_addr_w = '0;
  logic busy_o, sa_stall_o;
  logic [31:0] y_out [3:0];
  logic spad_x_csb0 = 1'b1, spad_w_csb0 = 1'b1;
  logic [5:0] spad_x_addr0 = '0, spad_w_addr0 = '0;
  logic [31:0] spad_x_din0 = '0, spad_w_din0 = '0;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  top_pd #(.N(4), .AW(6)) dut (
    .clk(clk), .n_rst(n_rst), .start_i(start_i),
    .base_addr_x(base_addr_x), .base_addr_w(base_addr_w),
    .busy_o(busy_o), .sa_stall_o(sa_stall_o), .y_out(y_out),
    .spad_x_csb0(spad_x_csb0), .spad_w_csb0(spad_w_csb0),
    .spad_x_addr0(spad_x_addr0), .spad_w_addr0(spad_w_addr0),
    .spad_x_din0(spad_x_din0), .spad_w_din0(spad_w_din0)
  );
  task automatic wr(input bit is_w, input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    if (is_w) begin
      spad_w_csb0 = 1'b0; spad_w_addr0 = a; spad_w_din0 = d;
    end else begin
      spad_x_csb0 = 1'b0; spad_x_addr0 = a; spad_x_din0 = d;
    end
    @(negedge clk);
    spad_x_csb0 = 1'b1;
    spad_w_csb0 = 1'b1;
  endtask
  task automatic run(input logic [5:0] bx, input logic [5:0] bw, input bit pulse,
                     output int bn, output int sn, output logic [31:0] ylast);
    @(negedge clk);
    base_addr_x = bx; base_addr_w = bw; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; bn = 0; sn = 0; ylast = '0;
    for (int c = 0; c < 100 && busy_o; c++) begin
      bn++;
      sn += int'(sa_stall_o);
      ylast = y_out[0];
      start_i = pulse && sn == 2;
      @(negedge clk);
    end
    start_i = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (busy_o !== 1'b0) $display("FAIL reset busy got %b want 0", busy_o); else passed++;
    checks++; if (sa_stall_o !== 1'b0) $display("FAIL reset stall got %b want 0", sa_stall_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (y_out[i] !== 32'h0) $display("FAIL reset y[%0d] got %h want 0", i, y_out[i]); else passed++;
    end
    n_rst = 1'b0;
  endtask
  task automatic test_basic;
    logic [31:0] e [4] = '{32'h40A00000, 32'h41400000, 32'h41A80000, 32'h42000000};
    logic [31:0] xs [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] ws [4] = '{32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    int bn, sn;
    logic [31:0] yl;
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, 6'(8 + i), xs[i]);
      wr(1'b1, 6'(16 + i), ws[i]);
    end
    run(6'd8, 6'd16, 1'b0, bn, sn, yl);
    checks++; if (bn !== 15) $display("FAIL basic busy_cycles got %0d want 15", bn); else passed++;
    checks++; if (sn !== 4) $display("FAIL basic stall_cycles got %0d want 4", sn); else passed++;
    checks++; if (yl !== 32'h0) $display("FAIL basic early_update got %h want 0", yl); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (y_out[i] !== e[i]) $display("FAIL basic y[%0d] got %h want %h", i, y_out[i], e[i]); else passed++;
    end
  endtask
  task automatic test_wrap;
    logic [31:0] e [4] = '{32'h40F00000, 32'hC0C00000, 32'h41600000, 32'h40800000};
    int bn, sn;
    logic [31:0] yl;
    wr(1'b0, 6'd62, 32'h3FC00000);
    wr(1'b0, 6'd63, 32'hBF800000);
    wr(1'b0, 6'd0, 32'h40000000);
    wr(1'b0, 6'd1, 32'h3F000000);
    run(6'd62, 6'd16, 1'b0, bn, sn, yl);
    checks++; if (bn !== 15) $display("FAIL wrap busy_cycles got %0d want 15", bn); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (y_out[i] !== e[i]) $display("FAIL wrap y[%0d] got %h want %h", i, y_out[i], e[i]); else passed++;
    end
  endtask
  task automatic test_start_ignored;
    int bn, sn;
    logic [31:0] yl;
    run(6'd8, 6'd16, 1'b1, bn, sn, yl);
    checks++; if (bn !== 15) $display("FAIL ignore busy_cycles got %0d want 15", bn); else passed++;
    checks++; if (sn !== 4) $display("FAIL ignore stall_cycles got %0d want 4", sn); else passed++;
    checks++; if (yl !== 32'h40F00000) $display("FAIL ignore early_update got %h want 40f00000", yl); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (busy_o !== 1'b0) $display("FAIL ignore busy_after got %b want 0", busy_o); else passed++;
    checks++; if (y_out[3] !== 32'h42000000) $display("FAIL ignore y[3] got %h want 42000000", y_out[3]); else passed++;
  endtask
  task automatic test_reset_mid;
    logic [31:0] e [4] = '{32'h40A00000, 32'h41400000, 32'h41A80000, 32'h42000000};
    int bn, sn;
    logic [31:0] yl;
    @(negedge clk);
    base_addr_x = 6'd8; base_addr_w = 6'd16; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (busy_o !== 1'b1) $display("FAIL midrst busy_before got %b want 1", busy_o); else passed++;
    n_rst = 1'b1;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) $display("FAIL midrst busy got %b want 0", busy_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (y_out[i] !== 32'h0) $display("FAIL midrst y[%0d] got %h want 0", i, y_out[i]); else passed++;
    end
    n_rst = 1'b0;
    run(6'd8, 6'd16, 1'b0, bn, sn, yl);
    checks++; if (bn !== 15) $display("FAIL rerun busy_cycles got %0d want 15", bn); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (y_out[i] !== e[i]) $display("FAIL rerun y[%0d] got %h want %h", i, y_out[i], e[i]); else passed++;
    end
  endtask
  task automatic test_special;
    logic [31:0] xs [4] = '{32'h7F800001, 32'hC0000000, 32'h7F000000, 32'h00000001};
    logic [31:0] ws [4] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'hC0000000};
    logic [31:0] e [4] = '{32'h7FC00000, 32'hC0C00000, 32'h7F800000, 32'h80000000};
    int bn, sn;
    logic [31:0] yl;
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, 6'(20 + i), xs[i]);
      wr(1'b1, 6'(24 + i), ws[i]);
    end
    run(6'd20, 6'd24, 1'b0, bn, sn, yl);
    for (int i = 0; i < 4; i++) begin
      checks++; if (y_out[i] !== e[i]) $display("FAIL special y[%0d] got %h want %h", i, y_out[i], e[i]); else passed++;
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_start_ignored;
    test_reset_mid;
    test_special;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
